// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle for dmem_port_arbiter: fetch port, LSU port, memory port and status.
// The arbiter takes the slave modport; requesters and the memory model sit on master.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_ack;
  logic [DATA_W-1:0] f_rdata;

  logic              l_req;
  logic              l_we;
  logic              l_byte;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_ack;
  logic [DATA_W-1:0] l_rdata;

  logic              mem_en;
  logic              mem_we;
  logic              mem_byte;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              grant;

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_byte, l_addr, l_wdata, mem_rdata,
    output f_ack, f_rdata, l_ack, l_rdata, mem_en, mem_we, mem_byte, mem_addr, mem_wdata,
           busy, grant
  );

  modport master (
    output f_req, f_addr, l_req, l_we, l_byte, l_addr, l_wdata, mem_rdata,
    input  f_ack, f_rdata, l_ack, l_rdata, mem_en, mem_we, mem_byte, mem_addr, mem_wdata,
           busy, grant
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between instruction fetch (F) and the LSU (L), one access at a time.
// Define DMEM_ARB_RR_EN for round-robin contention; default is fixed L-over-F priority.
module dmem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2,
  parameter int CNT_W       = 4
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  dmem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_last_grant, w_last_grant_nxt;
  logic                r_grant, w_grant_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_mem_en, w_mem_en_nxt;
  logic                r_mem_we, w_mem_we_nxt;
  logic                r_mem_byte, w_mem_byte_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic                r_f_ack, w_f_ack_nxt;
  logic [DATA_W-1:0]   r_f_rdata, w_f_rdata_nxt;
  logic                r_l_ack, w_l_ack_nxt;
  logic [DATA_W-1:0]   r_l_rdata, w_l_rdata_nxt;
  logic                w_pick_l;
  logic                w_respond;

`ifdef DMEM_ARB_RR_EN
  // Under contention the port that did not win last time goes first.
  assign w_pick_l = bus.l_req & (~bus.f_req | ~r_last_grant);
`else
  logic w_unused_last_grant;
  assign w_unused_last_grant = r_last_grant;
  assign w_pick_l = bus.l_req;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_busy       <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_byte   <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_f_ack      <= 1'b0;
      r_f_rdata    <= '0;
      r_l_ack      <= 1'b0;
      r_l_rdata    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_grant      <= w_grant_nxt;
      r_busy       <= w_busy_nxt;
      r_mem_en     <= w_mem_en_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_byte   <= w_mem_byte_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_f_ack      <= w_f_ack_nxt;
      r_f_rdata    <= w_f_rdata_nxt;
      r_l_ack      <= w_l_ack_nxt;
      r_l_rdata    <= w_l_rdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_last_grant_nxt = r_last_grant;
    w_grant_nxt      = r_grant;
    w_busy_nxt       = r_busy;
    w_mem_en_nxt     = 1'b0;
    w_mem_we_nxt     = r_mem_we;
    w_mem_byte_nxt   = r_mem_byte;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_f_ack_nxt      = 1'b0;
    w_f_rdata_nxt    = r_f_rdata;
    w_l_ack_nxt      = 1'b0;
    w_l_rdata_nxt    = r_l_rdata;
    w_respond        = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.f_req || bus.l_req) begin
          w_grant_nxt      = w_pick_l;
          w_last_grant_nxt = w_pick_l;
          w_busy_nxt       = 1'b1;
          w_mem_en_nxt     = 1'b1;
          w_state_nxt      = S_ISSUE;
          if (w_pick_l) begin
            w_mem_we_nxt    = bus.l_we;
            w_mem_byte_nxt  = bus.l_byte;
            w_mem_addr_nxt  = bus.l_byte ? bus.l_addr : {bus.l_addr[ADDR_W-1:2], 2'b00};
            w_mem_wdata_nxt = bus.l_byte ? {{(DATA_W-8){1'b0}}, bus.l_wdata[7:0]} : bus.l_wdata;
          end else begin
            w_mem_we_nxt    = 1'b0;
            w_mem_byte_nxt  = 1'b0;
            w_mem_addr_nxt  = {bus.f_addr[ADDR_W-1:2], 2'b00};
            w_mem_wdata_nxt = '0;
          end
        end
      end
      S_ISSUE: begin
        if (MEM_LATENCY == 1) begin
          w_respond = 1'b1;
        end else begin
          w_cnt_nxt   = CNT_W'(MEM_LATENCY - 1);
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // Read data is sampled on the edge where the counter runs out.
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_respond = 1'b1;
        end
      end
      S_RESP: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_respond) begin
      w_cnt_nxt   = '0;
      w_state_nxt = S_RESP;
      if (r_grant) begin
        w_l_ack_nxt = 1'b1;
        if (!r_mem_we) begin
          w_l_rdata_nxt = r_mem_byte ? {{(DATA_W-8){1'b0}}, bus.mem_rdata[7:0]} : bus.mem_rdata;
        end
      end else begin
        w_f_ack_nxt   = 1'b1;
        w_f_rdata_nxt = bus.mem_rdata;
      end
    end
  end

  assign bus.f_ack     = r_f_ack;
  assign bus.f_rdata   = r_f_rdata;
  assign bus.l_ack     = r_l_ack;
  assign bus.l_rdata   = r_l_rdata;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_byte  = r_mem_byte;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.busy      = r_busy;
  assign bus.grant     = r_grant;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: random and directed accesses against a reference model,
// on one instance with MEM_LATENCY=2 and one with MEM_LATENCY=1.
module tb_dmem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LAT    = 2;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstN = 1'b1;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) busA ();
  dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) busB ();

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LATENCY(LAT), .CNT_W(4)) dutA (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .bus     (busA.slave)
  );

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LATENCY(1), .CNT_W(4)) dutB (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .bus     (busB.slave)
  );

  int          checkCount = 0;
  int          errorCount = 0;
  logic [31:0] rdValA = '0;
  logic [31:0] rdValB = '0;
  int          cdA = 0;
  int          cdB = 0;
  int          enCntA = 0;
  logic [31:0] capAddrA = '0;
  logic [31:0] capWdataA = '0;
  logic        capWeA = 1'b0;
  logic        capByteA = 1'b0;
  logic [31:0] expFRdata = '0;
  logic [31:0] expLRdata = '0;
  bit          lastGrantM = 1'b1;
  int          edgesB;
  bit          doneB;

  // Memory A: captures the strobe and drives the read word only on the cycle it must be sampled.
  always @(negedge clk) begin : memModelA
    int nextCd;
    nextCd = cdA;
    if (busA.mem_en) begin
      enCntA    <= enCntA + 1;
      capAddrA  <= busA.mem_addr;
      capWeA    <= busA.mem_we;
      capByteA  <= busA.mem_byte;
      capWdataA <= busA.mem_wdata;
      nextCd    = LAT;
    end
    if (nextCd > 0) begin
      nextCd = nextCd - 1;
      busA.mem_rdata <= (nextCd == 0) ? rdValA : $urandom;
    end else begin
      busA.mem_rdata <= $urandom;
    end
    cdA <= nextCd;
  end

  always @(negedge clk) begin : memModelB
    int nextCd;
    nextCd = cdB;
    if (busB.mem_en) nextCd = 1;
    if (nextCd > 0) begin
      nextCd = nextCd - 1;
      busB.mem_rdata <= (nextCd == 0) ? rdValB : $urandom;
    end else begin
      busB.mem_rdata <= $urandom;
    end
    cdB <= nextCd;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " busy"},      busA.busy,      32'h0);
    checkOutput({tag, " grant"},     busA.grant,     32'h0);
    checkOutput({tag, " mem_en"},    busA.mem_en,    32'h0);
    checkOutput({tag, " mem_we"},    busA.mem_we,    32'h0);
    checkOutput({tag, " mem_byte"},  busA.mem_byte,  32'h0);
    checkOutput({tag, " mem_addr"},  busA.mem_addr,  32'h0);
    checkOutput({tag, " mem_wdata"}, busA.mem_wdata, 32'h0);
    checkOutput({tag, " f_ack"},     busA.f_ack,     32'h0);
    checkOutput({tag, " l_ack"},     busA.l_ack,     32'h0);
    checkOutput({tag, " f_rdata"},   busA.f_rdata,   expFRdata);
    checkOutput({tag, " l_rdata"},   busA.l_rdata,   expLRdata);
  endtask

  // One arbitration round on instance A with the requests currently presented.
  task automatic applyStimulus(input string tag, input bit keepWinner, input logic [31:0] rdData);
    bit          winL;
    bit          expWe, expByte, done;
    logic [31:0] expAddr, expWdata;
    int          startEn, edges;
    winL = busA.l_req && !(busA.f_req && RR && lastGrantM);
    lastGrantM = winL;
    if (winL) begin
      expWe    = busA.l_we;
      expByte  = busA.l_byte;
      expAddr  = busA.l_byte ? busA.l_addr : (busA.l_addr & ~32'h3);
      expWdata = busA.l_byte ? {24'h0, busA.l_wdata[7:0]} : busA.l_wdata;
      if (!expWe) expLRdata = expByte ? {24'h0, rdData[7:0]} : rdData;
    end else begin
      expWe    = 1'b0;
      expByte  = 1'b0;
      expAddr  = busA.f_addr & ~32'h3;
      expWdata = '0;
      expFRdata = rdData;
    end
    rdValA  = rdData;
    startEn = enCntA;
    done    = 1'b0;
    edges   = 0;
    while (!done && edges < 12) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) begin
        checkOutput({tag, " busy"},   busA.busy,   32'h1);
        checkOutput({tag, " grant"},  busA.grant,  {31'h0, winL});
        checkOutput({tag, " mem_en"}, busA.mem_en, 32'h1);
        if (winL) begin
          busA.l_addr  = $urandom;
          busA.l_wdata = $urandom;
          busA.l_we    = 1'($urandom_range(0, 1));
          busA.l_byte  = 1'($urandom_range(0, 1));
        end else begin
          busA.f_addr = $urandom;
        end
      end
      checkOutput({tag, " other ack"}, winL ? busA.f_ack : busA.l_ack, 32'h0);
      if (winL ? busA.l_ack : busA.f_ack) done = 1'b1;
    end
    if (!keepWinner) begin
      if (winL) busA.l_req = 1'b0;
      else      busA.f_req = 1'b0;
    end
    checkOutput({tag, " latency"},  edges,            LAT + 1);
    checkOutput({tag, " f_rdata"},  busA.f_rdata,     expFRdata);
    checkOutput({tag, " l_rdata"},  busA.l_rdata,     expLRdata);
    checkOutput({tag, " strobes"},  enCntA - startEn, 32'h1);
    checkOutput({tag, " mem_addr"}, capAddrA,         expAddr);
    checkOutput({tag, " mem_we"},   capWeA,           {31'h0, expWe});
    checkOutput({tag, " mem_byte"}, capByteA,         {31'h0, expByte});
    if (expWe) checkOutput({tag, " mem_wdata"}, capWdataA, expWdata);
    @(posedge clk);
    #1;
    checkOutput({tag, " busy drop"}, busA.busy,                 32'h0);
    checkOutput({tag, " ack pulse"}, busA.f_ack | busA.l_ack,   32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach its end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    busA.f_req = 0; busA.f_addr = '0; busA.l_req = 0; busA.l_we = 0;
    busA.l_byte = 0; busA.l_addr = '0; busA.l_wdata = '0;
    busB.f_req = 0; busB.f_addr = '0; busB.l_req = 0; busB.l_we = 0;
    busB.l_byte = 0; busB.l_addr = '0; busB.l_wdata = '0;
    #1 rstN = 1'b0;
    #1;
    checkResetState("reset");
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    busA.f_addr = 32'h103;
    busA.f_req  = 1'b1;
    applyStimulus("fetch", 1'b0, 32'hE3A01005);

    busA.l_we = 1'b1; busA.l_byte = 1'b1; busA.l_addr = 32'h201; busA.l_wdata = 32'hAABBCCDD;
    busA.l_req = 1'b1;
    applyStimulus("byte store", 1'b0, $urandom);

    busA.l_we = 1'b0; busA.l_byte = 1'b1; busA.l_addr = 32'h302; busA.l_wdata = $urandom;
    busA.l_req = 1'b1;
    applyStimulus("byte load", 1'b0, 32'h123456F0);

    for (int i = 0; i < 10; i++) begin
      busA.f_addr  = $urandom;
      busA.l_addr  = $urandom;
      busA.l_wdata = $urandom;
      busA.l_we    = 1'($urandom_range(0, 1));
      busA.l_byte  = 1'($urandom_range(0, 1));
      busA.f_req   = 1'($urandom_range(0, 1));
      busA.l_req   = 1'($urandom_range(0, 1));
      if (!busA.f_req) busA.l_req = 1'b1;
      while (busA.f_req || busA.l_req) applyStimulus("random", 1'b0, $urandom);
    end

    // Abandon an access in its wait state.
    busA.f_addr = $urandom;
    busA.f_req  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3 rstN = 1'b0;
    #1;
    expFRdata = '0; expLRdata = '0; lastGrantM = 1'b1;
    checkResetState("async reset");
    busA.f_req = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      checkOutput("no ack after reset", busA.f_ack | busA.l_ack, 32'h0);
    end
    busA.f_addr = $urandom;
    busA.f_req  = 1'b1;
    applyStimulus("fetch after reset", 1'b0, $urandom);

    rstN = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    expFRdata = '0; expLRdata = '0; lastGrantM = 1'b1;
    busA.f_addr = $urandom; busA.l_addr = $urandom; busA.l_wdata = $urandom;
    busA.l_we = 1'b0; busA.l_byte = 1'b0;
    busA.f_req = 1'b1; busA.l_req = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus("contention", 1'b1, $urandom);
    if (lastGrantM) busA.l_req = 1'b0;
    else            busA.f_req = 1'b0;
    applyStimulus("contention drain", 1'b0, $urandom);

    for (int r = 0; r < 2; r++) begin
      rdValB = $urandom;
      if (r == 0) begin
        busB.f_addr = $urandom;
        busB.f_req  = 1'b1;
      end else begin
        busB.l_we = 1'b0; busB.l_byte = 1'b0; busB.l_addr = $urandom;
        busB.l_req = 1'b1;
      end
      edgesB = 0;
      doneB  = 1'b0;
      while (!doneB && edgesB < 10) begin
        @(posedge clk);
        #1;
        edgesB++;
        if (busB.f_ack || busB.l_ack) doneB = 1'b1;
      end
      busB.f_req = 1'b0;
      busB.l_req = 1'b0;
      checkOutput("lat1 latency",   edgesB, 32'd2);
      checkOutput("lat1 owner ack", (r == 0) ? busB.f_ack : busB.l_ack, 32'h1);
      checkOutput("lat1 grant",     busB.grant, (r == 0) ? 32'h0 : 32'h1);
      checkOutput("lat1 rdata",     (r == 0) ? busB.f_rdata : busB.l_rdata, rdValB);
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
